// File: rtl/pong_pkg.sv
// Shared encodings and default grid geometry for the pong ball/paddle blocks.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_MISS = 2'd2
    } state_e;

    typedef enum logic {
        DX_POS = 1'b0,
        DX_NEG = 1'b1
    } dx_e;

    typedef enum logic {
        DY_DOWN = 1'b0,
        DY_UP   = 1'b1
    } dy_e;

    localparam int DEF_BIT_WIDTH = 3;
    localparam int DEF_ROW_BITS  = 3;
    localparam int DEF_SIZE      = 2;
    localparam int DEF_START_X   = 4;

endpackage

// File: rtl/ball_next.sv
// One ball step: wall reflection, then paddle check against the reflected column.
module ball_next
    import pong_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int ROW_BITS  = DEF_ROW_BITS,
    parameter int SIZE      = DEF_SIZE
) (
    input  logic [BIT_WIDTH-1:0] x_i,
    input  logic [ROW_BITS-1:0]  y_i,
    input  dx_e                  dx_i,
    input  dy_e                  dy_i,
    input  logic [BIT_WIDTH-1:0] paddle_left_i,
    output logic [BIT_WIDTH-1:0] x_n_o,
    output logic [ROW_BITS-1:0]  y_n_o,
    output dx_e                  dx_n_o,
    output dy_e                  dy_n_o,
    output logic                 hit_n_o,
    output logic                 miss_n_o
);

    localparam logic [BIT_WIDTH-1:0] MAX_X = '1;
    localparam logic [ROW_BITS-1:0]  MAX_Y = '1;

    logic [BIT_WIDTH:0] pad_lo, pad_hi, x_ext;
    logic               on_paddle;

    always_comb begin
        dx_n_o = dx_i;
        if (dx_i == DX_POS && x_i == MAX_X) begin
            dx_n_o = DX_NEG;
            x_n_o  = MAX_X - 1'b1;
        end else if (dx_i == DX_NEG && x_i == '0) begin
            dx_n_o = DX_POS;
            x_n_o  = BIT_WIDTH'(1);
        end else if (dx_i == DX_POS) begin
            x_n_o  = x_i + 1'b1;
        end else begin
            x_n_o  = x_i - 1'b1;
        end
    end

    // One extra bit so paddle_left+SIZE cannot wrap back into the grid.
    assign x_ext     = {1'b0, x_n_o};
    assign pad_lo    = {1'b0, paddle_left_i};
    assign pad_hi    = pad_lo + (BIT_WIDTH+1)'(SIZE);
    assign on_paddle = (x_ext >= pad_lo) && (x_ext <= pad_hi);

    always_comb begin
        dy_n_o   = dy_i;
        hit_n_o  = 1'b0;
        miss_n_o = 1'b0;
        if (dy_i == DY_UP && y_i == '0) begin
            dy_n_o = DY_DOWN;
            y_n_o  = ROW_BITS'(1);
        end else if (dy_i == DY_DOWN && y_i == MAX_Y - 1'b1) begin
            if (on_paddle) begin
                hit_n_o = 1'b1;
                dy_n_o  = DY_UP;
                y_n_o   = MAX_Y - ROW_BITS'(2);
            end else begin
                miss_n_o = 1'b1;
                y_n_o    = MAX_Y;
            end
        end else if (dy_i == DY_DOWN) begin
            y_n_o = y_i + 1'b1;
        end else begin
            y_n_o = y_i - 1'b1;
        end
    end

endmodule

// File: rtl/state_ball.sv
// Ball FSM and position/score registers; step arithmetic lives in ball_next.
module state_ball
    import pong_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int ROW_BITS  = DEF_ROW_BITS,
    parameter int SIZE      = DEF_SIZE,
    parameter int START_X   = DEF_START_X
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 tick,
    input  logic [BIT_WIDTH-1:0] paddle_left,
    output logic [BIT_WIDTH-1:0] ball_x,
    output logic [ROW_BITS-1:0]  ball_y,
    output logic                 hit,
    output logic                 miss,
    output logic [3:0]           score,
    output logic                 playing
);

    state_e               state_q, state_d;
    logic [BIT_WIDTH-1:0] x_q, x_d, x_n;
    logic [ROW_BITS-1:0]  y_q, y_d, y_n;
    dx_e                  dx_q, dx_d, dx_n;
    dy_e                  dy_q, dy_d, dy_n;
    logic [3:0]           score_q, score_d;
    logic                 hit_q, hit_d, miss_q, miss_d;
    logic                 hit_n, miss_n, step;

    ball_next #(
        .BIT_WIDTH(BIT_WIDTH),
        .ROW_BITS (ROW_BITS),
        .SIZE     (SIZE)
    ) u_next (
        .x_i          (x_q),
        .y_i          (y_q),
        .dx_i         (dx_q),
        .dy_i         (dy_q),
        .paddle_left_i(paddle_left),
        .x_n_o        (x_n),
        .y_n_o        (y_n),
        .dx_n_o       (dx_n),
        .dy_n_o       (dy_n),
        .hit_n_o      (hit_n),
        .miss_n_o     (miss_n)
    );

    assign step = (state_q == ST_RUN) && en && tick;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en) state_d = ST_RUN;
            ST_RUN: begin
                if (!en)              state_d = ST_IDLE;
                else if (tick && miss_n) state_d = ST_MISS;
            end
            ST_MISS: if (!en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        playing = (state_q == ST_RUN);
    end

    // IDLE and any drop of en re-serve the ball, so leaving RUN/MISS lands at the serve point.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        score_d = score_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        if (state_q == ST_IDLE || !en) begin
            x_d     = BIT_WIDTH'(START_X);
            y_d     = '0;
            dx_d    = DX_POS;
            dy_d    = DY_DOWN;
            score_d = '0;
        end else if (step) begin
            x_d    = x_n;
            y_d    = y_n;
            dx_d   = dx_n;
            dy_d   = dy_n;
            hit_d  = hit_n;
            miss_d = miss_n;
            if (hit_n && score_q != 4'hF) score_d = score_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= BIT_WIDTH'(START_X);
            y_q     <= '0;
            dx_q    <= DX_POS;
            dy_q    <= DY_DOWN;
            score_q <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            score_q <= score_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    assign ball_x = x_q;
    assign ball_y = y_q;
    assign hit    = hit_q;
    assign miss   = miss_q;
    assign score  = score_q;

endmodule

// File: tb/tb_state_ball.sv
// Directed bench for state_ball at default geometry (8x8 grid, paddle width 3, serve column 4).
module tb_state_ball;

    logic       clk = 1'b0;
    logic       rst, en, tick;
    logic [2:0] paddle_left;
    logic [2:0] ball_x, ball_y;
    logic       hit, miss, playing;
    logic [3:0] score;

    int tests = 0;
    int fails = 0;

    state_ball dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .tick       (tick),
        .paddle_left(paddle_left),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .hit        (hit),
        .miss       (miss),
        .score      (score),
        .playing    (playing)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle; inputs are changed only after this returns.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From any state: return to IDLE, start a rally and take the six serve ticks to (4,6).
    task automatic serve_six();
        en = 1'b0; tick = 1'b0;
        step();
        en = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; tick = 1'b1; paddle_left = 3'd2;
        step();
        rst = 1'b0; en = 1'b0; tick = 1'b0;
        tests++;
        if (ball_x !== 3'd4 || ball_y !== 3'd0 || hit !== 1'b0 || miss !== 1'b0 ||
            score !== 4'd0 || playing !== 1'b0) begin
            fails++;
            $display("FAIL reset: x=%0d y=%0d hit=%b miss=%b score=%0d playing=%b, want 4 0 0 0 0 0",
                     ball_x, ball_y, hit, miss, score, playing);
        end
    endtask

    task automatic test_serve_idle();
        en = 1'b1; tick = 1'b1;  // tick on the IDLE->RUN cycle is ignored
        step();
        tick = 1'b0;
        tests++;
        if (playing !== 1'b1 || ball_x !== 3'd4 || ball_y !== 3'd0 || score !== 4'd0) begin
            fails++;
            $display("FAIL serve_start: playing=%b x=%0d y=%0d score=%0d, want 1 4 0 0",
                     playing, ball_x, ball_y, score);
        end
        step(); step();
        tests++;
        if (playing !== 1'b1 || ball_x !== 3'd4 || ball_y !== 3'd0) begin
            fails++;
            $display("FAIL serve_hold: playing=%b x=%0d y=%0d, want 1 4 0", playing, ball_x, ball_y);
        end
    endtask

    task automatic test_walk();
        logic [2:0] ex[6];
        logic [2:0] ey[6];
        ex = '{3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4};
        ey = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        for (int i = 0; i < 6; i++) begin
            tick = 1'b1; step();
            tick = 1'b0;
            tests++;
            if (ball_x !== ex[i] || ball_y !== ey[i] || hit !== 1'b0 || miss !== 1'b0) begin
                fails++;
                $display("FAIL walk_tick%0d: got (%0d,%0d) hit=%b miss=%b, want (%0d,%0d) 0 0",
                         i + 1, ball_x, ball_y, hit, miss, ex[i], ey[i]);
            end
            step();
            tests++;
            if (ball_x !== ex[i] || ball_y !== ey[i]) begin
                fails++;
                $display("FAIL walk_idle%0d: got (%0d,%0d), want (%0d,%0d)",
                         i + 1, ball_x, ball_y, ex[i], ey[i]);
            end
        end
    endtask

    task automatic test_hit();
        paddle_left = 3'd2;
        tick = 1'b1; step();
        tick = 1'b0;
        tests++;
        if (ball_x !== 3'd3 || ball_y !== 3'd5 || hit !== 1'b1 || miss !== 1'b0 || score !== 4'd1) begin
            fails++;
            $display("FAIL hit: got (%0d,%0d) hit=%b miss=%b score=%0d, want (3,5) 1 0 1",
                     ball_x, ball_y, hit, miss, score);
        end
        step();
        tests++;
        if (hit !== 1'b0 || score !== 4'd1) begin
            fails++;
            $display("FAIL hit_pulse: hit=%b score=%0d, want 0 1", hit, score);
        end
        // dy now up, dx still -1
        tick = 1'b1; step();
        tick = 1'b0;
        tests++;
        if (ball_x !== 3'd2 || ball_y !== 3'd4 || playing !== 1'b1) begin
            fails++;
            $display("FAIL hit_rebound: got (%0d,%0d) playing=%b, want (2,4) 1", ball_x, ball_y, playing);
        end
    endtask

    task automatic test_miss();
        en = 1'b0; step();
        tests++;
        if (ball_x !== 3'd4 || ball_y !== 3'd0 || score !== 4'd0 || playing !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_hit: got (%0d,%0d) score=%0d playing=%b, want (4,0) 0 0",
                     ball_x, ball_y, score, playing);
        end
        serve_six();
        paddle_left = 3'd5;
        tick = 1'b1; step();
        tick = 1'b0;
        tests++;
        if (ball_x !== 3'd3 || ball_y !== 3'd7 || miss !== 1'b1 || hit !== 1'b0 || playing !== 1'b0) begin
            fails++;
            $display("FAIL miss: got (%0d,%0d) miss=%b hit=%b playing=%b, want (3,7) 1 0 0",
                     ball_x, ball_y, miss, hit, playing);
        end
        step();
        tests++;
        if (miss !== 1'b0) begin
            fails++;
            $display("FAIL miss_pulse: miss=%b, want 0", miss);
        end
        tick = 1'b1; step(); step();
        tick = 1'b0;
        tests++;
        if (ball_x !== 3'd3 || ball_y !== 3'd7 || playing !== 1'b0 || miss !== 1'b0) begin
            fails++;
            $display("FAIL miss_hold: got (%0d,%0d) playing=%b miss=%b, want (3,7) 0 0",
                     ball_x, ball_y, playing, miss);
        end
        en = 1'b0; step();
        tests++;
        if (ball_x !== 3'd4 || ball_y !== 3'd0 || score !== 4'd0 || playing !== 1'b0) begin
            fails++;
            $display("FAIL miss_to_idle: got (%0d,%0d) score=%0d playing=%b, want (4,0) 0 0",
                     ball_x, ball_y, score, playing);
        end
    endtask

    task automatic test_paddle_edges();
        // Right edge: paddle 1..3, ball lands on 3
        serve_six();
        paddle_left = 3'd1;
        tick = 1'b1; step();
        tick = 1'b0;
        tests++;
        if (hit !== 1'b1 || miss !== 1'b0 || ball_x !== 3'd3 || ball_y !== 3'd5) begin
            fails++;
            $display("FAIL paddle_right_edge: hit=%b miss=%b (%0d,%0d), want 1 0 (3,5)",
                     hit, miss, ball_x, ball_y);
        end
        // Left edge just missed: paddle 4..6
        serve_six();
        paddle_left = 3'd4;
        tick = 1'b1; step();
        tick = 1'b0;
        tests++;
        if (hit !== 1'b0 || miss !== 1'b1 || ball_y !== 3'd7) begin
            fails++;
            $display("FAIL paddle_left_gap: hit=%b miss=%b y=%0d, want 0 1 7", hit, miss, ball_y);
        end
        // paddle 6..8 must not wrap around to cover column 3
        serve_six();
        paddle_left = 3'd6;
        tick = 1'b1; step();
        tick = 1'b0;
        tests++;
        if (hit !== 1'b0 || miss !== 1'b1) begin
            fails++;
            $display("FAIL paddle_nowrap: hit=%b miss=%b, want 0 1", hit, miss);
        end
    endtask

    task automatic test_en_priority();
        en = 1'b0; step();
        en = 1'b1; step();
        tick = 1'b1; step(); step();
        tick = 1'b0;
        tests++;
        if (ball_x !== 3'd6 || ball_y !== 3'd2) begin
            fails++;
            $display("FAIL back_to_back: got (%0d,%0d), want (6,2)", ball_x, ball_y);
        end
        en = 1'b0; tick = 1'b1; step();
        tick = 1'b0;
        tests++;
        if (ball_x !== 3'd4 || ball_y !== 3'd0 || playing !== 1'b0 || hit !== 1'b0 || miss !== 1'b0) begin
            fails++;
            $display("FAIL en_over_tick: got (%0d,%0d) playing=%b hit=%b miss=%b, want (4,0) 0 0 0",
                     ball_x, ball_y, playing, hit, miss);
        end
    endtask

    task automatic test_rst_priority();
        en = 1'b1; step();
        tick = 1'b1; step(); step();
        rst = 1'b1; step();
        rst = 1'b0; tick = 1'b0;
        tests++;
        if (ball_x !== 3'd4 || ball_y !== 3'd0 || playing !== 1'b0 || score !== 4'd0 ||
            hit !== 1'b0 || miss !== 1'b0) begin
            fails++;
            $display("FAIL rst_in_run: got (%0d,%0d) playing=%b score=%0d hit=%b miss=%b, want (4,0) 0 0 0 0",
                     ball_x, ball_y, playing, score, hit, miss);
        end
        serve_six();
        paddle_left = 3'd5;
        tick = 1'b1; step();
        rst = 1'b1; step();
        rst = 1'b0; tick = 1'b0;
        tests++;
        if (ball_x !== 3'd4 || ball_y !== 3'd0 || playing !== 1'b0 || score !== 4'd0 ||
            hit !== 1'b0 || miss !== 1'b0) begin
            fails++;
            $display("FAIL rst_in_miss: got (%0d,%0d) playing=%b score=%0d hit=%b miss=%b, want (4,0) 0 0 0 0",
                     ball_x, ball_y, playing, score, hit, miss);
        end
        step();
        tests++;
        if (playing !== 1'b1) begin
            fails++;
            $display("FAIL rst_release: playing=%b, want 1", playing);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; tick = 1'b0; paddle_left = 3'd2;
        #2;
        test_reset();
        test_serve_idle();
        test_walk();
        test_hit();
        test_miss();
        test_paddle_edges();
        test_en_priority();
        test_rst_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
